// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output ser_out,
        output ser_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out word serializer, zero-gap streaming
// Define SER_PARITY_EN to append an even-parity bit after each word.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    piso_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef SER_PARITY_EN
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             last_bit;
    logic             load_ready;
    logic             accept;
    logic             first_bit;
    logic             next_bit;

    assign last_bit = (state_q == SHIFT) && (count_q == LAST);

    // Ready is decoded from state only; gated by rst so it stays low while held in reset.
`ifdef SER_PARITY_EN
    assign load_ready = rst && ((state_q == IDLE) || (state_q == PARITY));
`else
    assign load_ready = rst && ((state_q == IDLE) || last_bit);
`endif
    assign accept    = bus.load_valid && load_ready;
    assign first_bit = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
    assign next_bit  = MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        word_done_d = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        if (accept) begin
            state_d     = SHIFT;
            shift_d     = bus.load_data;
            count_d     = '0;
            ser_out_d   = first_bit;
            ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
            par_d       = ^bus.load_data;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (count_q != LAST) begin
                        shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                              : {1'b0, shift_q[WIDTH-1:1]};
                        count_d   = count_q + 1'b1;
                        ser_out_d = next_bit;
`ifndef SER_PARITY_EN
                        word_done_d = (count_q == PENULT);
`endif
                    end else begin
`ifdef SER_PARITY_EN
                        state_d     = PARITY;
                        ser_out_d   = par_q;
                        word_done_d = 1'b1;
`else
                        state_d     = IDLE;
                        shift_d     = '0;
                        count_d     = '0;
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d     = IDLE;
                    shift_d     = '0;
                    count_d     = '0;
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.word_done  = word_done_q;
    assign bus.busy       = ser_valid_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;
    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = WIDTH + PAR;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(WIDTH)) m_if ();
    piso_serializer_if #(.WIDTH(WIDTH)) l_if ();

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if.slave)
    );

    // Expected serial bit on cycle c (1-based) of a word, parity bit after the data.
    function automatic logic exp_bit(input logic [7:0] w, input int c, input bit msb);
        if (c <= WIDTH) return msb ? w[WIDTH-c] : w[c-1];
        return ^w;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (m_if.ser_out !== 1'b0 || m_if.ser_valid !== 1'b0 || m_if.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_outs got out=%b valid=%b busy=%b want 0/0/0", m_if.ser_out, m_if.ser_valid, m_if.busy);
        end
        n_cmp++; if (m_if.word_done !== 1'b0 || m_if.load_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready got done=%b ready=%b want 0/0", m_if.word_done, m_if.load_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (m_if.load_ready !== 1'b1 || l_if.load_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready got %b/%b want 1/1", m_if.load_ready, l_if.load_ready);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w = 8'hB0;
        logic [4:0] hist = '0;
        int hits = 0;
        logic e;
        @(negedge clk);
        m_if.load_data  = w;
        m_if.load_valid = 1'b1;
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            m_if.load_valid = 1'b0;
            e = exp_bit(w, c, 1'b1);
            n_cmp++; if (m_if.ser_out !== e || m_if.ser_valid !== 1'b1 || m_if.busy !== 1'b1) begin
                n_bad++; $display("FAIL single_bit c=%0d got out=%b valid=%b busy=%b want %b/1/1", c, m_if.ser_out, m_if.ser_valid, m_if.busy, e);
            end
            n_cmp++; if (m_if.word_done !== (c == L)) begin
                n_bad++; $display("FAIL single_done c=%0d got %b want %b", c, m_if.word_done, (c == L));
            end
            n_cmp++; if (m_if.load_ready !== (c == L)) begin
                n_bad++; $display("FAIL single_ready c=%0d got %b want %b", c, m_if.load_ready, (c == L));
            end
            hist = {hist[3:0], m_if.ser_out};
            if (hist == 5'b10110) hits++;
        end
        @(negedge clk);
        n_cmp++; if (m_if.ser_valid !== 1'b0 || m_if.ser_out !== 1'b0 || m_if.load_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_idle got valid=%b out=%b ready=%b want 0/0/1", m_if.ser_valid, m_if.ser_out, m_if.load_ready);
        end
        n_cmp++; if (hits != 1) begin
            n_bad++; $display("FAIL single_detect got %0d want 1", hits);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        int ci;
        logic e;
        @(negedge clk);
        n_cmp++; if (m_if.load_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready0 got %b want 1", m_if.load_ready);
        end
        m_if.load_data  = 8'hB0;
        m_if.load_valid = 1'b1;
        for (int c = 1; c <= 2 * L; c++) begin
            @(negedge clk);
            if (c == 1) m_if.load_data = 8'h5A;
            w  = (c <= L) ? 8'hB0 : 8'h5A;
            ci = (c <= L) ? c : c - L;
            e  = exp_bit(w, ci, 1'b1);
            n_cmp++; if (m_if.ser_out !== e || m_if.ser_valid !== 1'b1) begin
                n_bad++; $display("FAIL b2b_bit c=%0d got out=%b valid=%b want %b/1", c, m_if.ser_out, m_if.ser_valid, e);
            end
            n_cmp++; if (m_if.load_ready !== (c == L || c == 2 * L)) begin
                n_bad++; $display("FAIL b2b_ready c=%0d got %b want %b", c, m_if.load_ready, (c == L || c == 2 * L));
            end
            if (c == 2 * L) m_if.load_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (m_if.ser_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle got valid=%b want 0", m_if.ser_valid);
        end
    endtask

    task automatic test_hold_while_busy();
        logic [7:0] w;
        int ci;
        logic e;
        @(negedge clk);
        m_if.load_data  = 8'h3C;
        m_if.load_valid = 1'b1;
        for (int c = 1; c <= 2 * L; c++) begin
            @(negedge clk);
            if (c == 1) m_if.load_valid = 1'b0;
            w  = (c <= L) ? 8'h3C : 8'hFF;
            ci = (c <= L) ? c : c - L;
            e  = exp_bit(w, ci, 1'b1);
            n_cmp++; if (m_if.ser_out !== e || m_if.ser_valid !== 1'b1) begin
                n_bad++; $display("FAIL hold_bit c=%0d got out=%b valid=%b want %b/1", c, m_if.ser_out, m_if.ser_valid, e);
            end
            n_cmp++; if (m_if.load_ready !== (c == L || c == 2 * L)) begin
                n_bad++; $display("FAIL hold_ready c=%0d got %b want %b", c, m_if.load_ready, (c == L || c == 2 * L));
            end
            if (c == 3) begin
                m_if.load_data  = 8'hFF;
                m_if.load_valid = 1'b1;
            end
            if (c == L + 1) m_if.load_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (m_if.ser_valid !== 1'b0 || m_if.load_ready !== 1'b1) begin
            n_bad++; $display("FAIL hold_idle got valid=%b ready=%b want 0/1", m_if.ser_valid, m_if.load_ready);
        end
    endtask

    task automatic test_reset_mid_word();
        logic e;
        @(negedge clk);
        m_if.load_data  = 8'hB0;
        m_if.load_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            m_if.load_valid = 1'b0;
            e = exp_bit(8'hB0, c, 1'b1);
            n_cmp++; if (m_if.ser_out !== e) begin
                n_bad++; $display("FAIL rstmid_bit c=%0d got %b want %b", c, m_if.ser_out, e);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (m_if.ser_out !== 1'b0 || m_if.ser_valid !== 1'b0 || m_if.busy !== 1'b0 || m_if.word_done !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_abort got out=%b valid=%b busy=%b done=%b want 0/0/0/0", m_if.ser_out, m_if.ser_valid, m_if.busy, m_if.word_done);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (m_if.load_ready !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_ready got %b want 1", m_if.load_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (m_if.ser_valid !== 1'b0 || m_if.ser_out !== 1'b0) begin
                n_bad++; $display("FAIL rstmid_residual c=%0d got valid=%b out=%b want 0/0", c, m_if.ser_valid, m_if.ser_out);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic e;
        @(negedge clk);
        l_if.load_data  = 8'h0D;
        l_if.load_valid = 1'b1;
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            l_if.load_valid = 1'b0;
            e = exp_bit(8'h0D, c, 1'b0);
            n_cmp++; if (l_if.ser_out !== e || l_if.ser_valid !== 1'b1) begin
                n_bad++; $display("FAIL lsb_bit c=%0d got out=%b valid=%b want %b/1", c, l_if.ser_out, l_if.ser_valid, e);
            end
            n_cmp++; if (l_if.word_done !== (c == L)) begin
                n_bad++; $display("FAIL lsb_done c=%0d got %b want %b", c, l_if.word_done, (c == L));
            end
        end
        @(negedge clk);
        n_cmp++; if (l_if.ser_valid !== 1'b0) begin
            n_bad++; $display("FAIL lsb_idle got valid=%b want 0", l_if.ser_valid);
        end
    endtask

    initial begin
        m_if.load_data  = '0;
        m_if.load_valid = 1'b0;
        l_if.load_data  = '0;
        l_if.load_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold_while_busy();
        test_reset_mid_word();
        test_lsb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
